pspin_her_sched: RTL and testbench

- Schedules ingress-DMA completions from NUM_SRC channels onto the single completion input of the HER generator.
- Round-robin arbitration across channels, gated by per-execution-context in-flight limits.
- Credits are returned by handler-completion feedback from PsPIN.
- Sequences safe reconfiguration of the HER generator: stops dispatch, drains every in-flight HER, then pulses the generator's config-valid.

---
 rtl/pspin_her_sched.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_pspin_her_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_her_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pspin_her_sched
//  Purpose  : Schedules ingress-DMA completions from NUM_SRC channels onto the
//             single completion input of the HER generator. Round-robin
//             arbitration gated by per-execution-context in-flight limits;
//             credits come back through handler-completion feedback. Also
//             sequences a safe reconfiguration: stop dispatch, drain every
//             in-flight HER, then pulse the generator's config-valid.
//  Ports    : clk, rstn (synchronous, active-low)
//             src_addr/len/tag/valid/ready  - per-source completion inputs
//             gen_addr/len/tag/valid/ready  - single output slot to generator
//             fb_valid/fb_ctx_id            - handler completion feedback
//             cfg_req/cfg_ctx_enabled/cfg_ctx_limit/cfg_ack - reconfiguration
//             conf_valid                    - config latch pulse to generator
//             busy                          - high while draining / applying
//             err_credit                    - sticky feedback-underflow flag
//  Options  : `define PSPIN_HER_SCHED_STATS_EN adds stat_grants (per-source
//             grant counters) and stat_stall_cycles (saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module pspin_her_sched #(
   parameter int NUM_SRC         = 4,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH       = 20,
   parameter int TAG_WIDTH       = 32,
   parameter int NUM_HANDLER_CTX = 8,
   parameter int CREDIT_WIDTH    = 8,
   localparam int CTX_ID_WIDTH   = (NUM_HANDLER_CTX > 1) ? $clog2(NUM_HANDLER_CTX) : 1
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0]       src_addr,
   input  logic [NUM_SRC*LEN_WIDTH-1:0]            src_len,
   input  logic [NUM_SRC*TAG_WIDTH-1:0]            src_tag,
   input  logic [NUM_SRC-1:0]                      src_valid,
   output logic [NUM_SRC-1:0]                      src_ready,
   output logic [AXI_ADDR_WIDTH-1:0]               gen_addr,
   output logic [LEN_WIDTH-1:0]                    gen_len,
   output logic [TAG_WIDTH-1:0]                    gen_tag,
   output logic                                    gen_valid,
   input  logic                                    gen_ready,
   input  logic                                    fb_valid,
   input  logic [CTX_ID_WIDTH-1:0]                 fb_ctx_id,
   input  logic                                    cfg_req,
   input  logic [NUM_HANDLER_CTX-1:0]              cfg_ctx_enabled,
   input  logic [NUM_HANDLER_CTX*CREDIT_WIDTH-1:0] cfg_ctx_limit,
   output logic                                    cfg_ack,
   output logic                                    conf_valid,
   output logic                                    busy,
   output logic                                    err_credit
`ifdef PSPIN_HER_SCHED_STATS_EN
   ,
   output logic [NUM_SRC*32-1:0]                   stat_grants,
   output logic [31:0]                             stat_stall_cycles
`endif
);

   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_APPLY = 2'd2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]                 state_q;
   logic [1:0]                 state_d;
   logic                       cfg_armed_q;
   logic [NUM_HANDLER_CTX-1:0] ctx_enabled_q;
   logic [CREDIT_WIDTH-1:0]    ctx_limit_q [NUM_HANDLER_CTX];
   logic [CREDIT_WIDTH-1:0]    cnt_q       [NUM_HANDLER_CTX];
   logic [SRC_W-1:0]           rr_ptr_q;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [CTX_ID_WIDTH-1:0]    src_ctx [NUM_SRC];
   logic [NUM_SRC-1:0]         eligible;
   logic                       grant_found;
   logic [SRC_W-1:0]           grant_idx;
   logic                       grant_en;
   logic                       grant;
   logic [CTX_ID_WIDTH-1:0]    grant_ctx;
   logic                       slot_free;
   logic                       cnt_all_zero;
   logic [NUM_HANDLER_CTX-1:0] cnt_inc;
   logic [NUM_HANDLER_CTX-1:0] cnt_dec;

   assign slot_free = !gen_valid || gen_ready;

   // Per-source effective context and credit check. Tags addressing a
   // disabled context are folded onto context 0 so every completion is
   // always charged somewhere that feedback can later release.
   generate
      for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
         logic [CTX_ID_WIDTH-1:0] raw_ctx;
         logic [CREDIT_WIDTH-1:0] cur_cnt;
         logic [CREDIT_WIDTH-1:0] cur_lim;

         assign raw_ctx    = src_tag[s*TAG_WIDTH +: CTX_ID_WIDTH];
         assign src_ctx[s] = ctx_enabled_q[raw_ctx] ? raw_ctx : '0;
         assign cur_cnt    = cnt_q[src_ctx[s]];
         assign cur_lim    = ctx_limit_q[src_ctx[s]];
         // A zero limit means unlimited, but the counter must still never wrap.
         assign eligible[s] = src_valid[s] &&
                              ((cur_lim == '0) ? (cur_cnt != '1) : (cur_cnt < cur_lim));
      end
   endgenerate

   // Round-robin search: first eligible source at or after rr_ptr_q.
   always_comb begin
      int               idx;
      logic [SRC_W-1:0] idx_s;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         idx_s = SRC_W'(idx);
         if (!grant_found && eligible[idx_s]) begin
            grant_found = 1'b1;
            grant_idx   = idx_s;
         end
      end
   end

   assign grant     = grant_en && grant_found;
   assign grant_ctx = src_ctx[grant_idx];

   always_comb begin
      src_ready = '0;
      if (grant) begin
         src_ready[grant_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output slot and round-robin pointer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         gen_valid <= 1'b0;
         gen_addr  <= '0;
         gen_len   <= '0;
         gen_tag   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         if (grant) begin
            gen_valid <= 1'b1;
            gen_addr  <= src_addr[int'(grant_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            gen_len   <= src_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
            gen_tag   <= src_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
            rr_ptr_q  <= (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + SRC_W'(1);
         end else if (gen_ready) begin
            gen_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Credit accounting
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_inc      = '0;
      cnt_dec      = '0;
      cnt_all_zero = 1'b1;
      for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
         cnt_inc[c] = grant && (grant_ctx == CTX_ID_WIDTH'(c));
         cnt_dec[c] = fb_valid && (fb_ctx_id == CTX_ID_WIDTH'(c));
         if (cnt_q[c] != '0) begin
            cnt_all_zero = 1'b0;
         end
      end
   end

   // A charge and a release on the same context cancel out; a release on an
   // empty counter is an underflow that is flagged rather than wrapped.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_credit <= 1'b0;
         for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
            if (cnt_inc[c] && !cnt_dec[c]) begin
               cnt_q[c] <= cnt_q[c] + CREDIT_WIDTH'(1);
            end else if (cnt_dec[c] && !cnt_inc[c]) begin
               if (cnt_q[c] == '0) begin
                  err_credit <= 1'b1;
               end else begin
                  cnt_q[c] <= cnt_q[c] - CREDIT_WIDTH'(1);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Configuration latch
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ctx_enabled_q <= '0;
         for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
            ctx_limit_q[c] <= '0;
         end
      end else if (state_q == ST_APPLY) begin
         ctx_enabled_q <= cfg_ctx_enabled;
         for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
            ctx_limit_q[c] <= cfg_ctx_limit[c*CREDIT_WIDTH +: CREDIT_WIDTH];
         end
      end
   end

   // A request still held after its ack must not start a second drain; the
   // request line has to be observed low first (sampling it in APPLY too, so
   // a requester that drops it immediately is re-armed without a gap).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cfg_armed_q <= 1'b1;
      end else if (state_q == ST_APPLY) begin
         cfg_armed_q <= !cfg_req;
      end else if (!cfg_req) begin
         cfg_armed_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Reconfiguration FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (cfg_req && cfg_armed_q) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!gen_valid && cnt_all_zero) begin
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Dispatch stops in the very cycle a request is accepted, so nothing new
   // is charged once the drain has been decided.
   always_comb begin
      busy       = 1'b0;
      cfg_ack    = 1'b0;
      conf_valid = 1'b0;
      grant_en   = 1'b0;
      case (state_q)
         ST_RUN: begin
            grant_en = rstn && slot_free && !(cfg_req && cfg_armed_q);
         end
         ST_DRAIN: begin
            busy = 1'b1;
         end
         ST_APPLY: begin
            busy       = 1'b1;
            cfg_ack    = 1'b1;
            conf_valid = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

`ifdef PSPIN_HER_SCHED_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stat_grants       <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (grant) begin
            stat_grants[int'(grant_idx)*32 +: 32] <= stat_grants[int'(grant_idx)*32 +: 32] + 32'd1;
         end
         if ((|src_valid) && !grant && (stat_stall_cycles != '1)) begin
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pspin_her_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pspin_her_sched
//  Purpose  : Directed self-checking bench for pspin_her_sched with
//             hand-computed expectations (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pspin_her_sched;

   localparam int NS  = 4;
   localparam int AW  = 32;
   localparam int LW  = 20;
   localparam int TW  = 32;
   localparam int NC  = 8;
   localparam int CW  = 8;
   localparam int CIW = 3;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NS*AW-1:0]  src_addr;
   logic [NS*LW-1:0]  src_len;
   logic [NS*TW-1:0]  src_tag;
   logic [NS-1:0]     src_valid;
   logic [NS-1:0]     src_ready;
   logic [AW-1:0]     gen_addr;
   logic [LW-1:0]     gen_len;
   logic [TW-1:0]     gen_tag;
   logic              gen_valid;
   logic              gen_ready;
   logic              fb_valid;
   logic [CIW-1:0]    fb_ctx_id;
   logic              cfg_req;
   logic [NC-1:0]     cfg_ctx_enabled;
   logic [NC*CW-1:0]  cfg_ctx_limit;
   logic              cfg_ack;
   logic              conf_valid;
   logic              busy;
   logic              err_credit;
`ifdef PSPIN_HER_SCHED_STATS_EN
   logic [NS*32-1:0]  stat_grants;
   logic [31:0]       stat_stall_cycles;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pspin_her_sched #(
      .NUM_SRC         (NS),
      .AXI_ADDR_WIDTH  (AW),
      .LEN_WIDTH       (LW),
      .TAG_WIDTH       (TW),
      .NUM_HANDLER_CTX (NC),
      .CREDIT_WIDTH    (CW)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .src_addr        (src_addr),
      .src_len         (src_len),
      .src_tag         (src_tag),
      .src_valid       (src_valid),
      .src_ready       (src_ready),
      .gen_addr        (gen_addr),
      .gen_len         (gen_len),
      .gen_tag         (gen_tag),
      .gen_valid       (gen_valid),
      .gen_ready       (gen_ready),
      .fb_valid        (fb_valid),
      .fb_ctx_id       (fb_ctx_id),
      .cfg_req         (cfg_req),
      .cfg_ctx_enabled (cfg_ctx_enabled),
      .cfg_ctx_limit   (cfg_ctx_limit),
      .cfg_ack         (cfg_ack),
      .conf_valid      (conf_valid),
      .busy            (busy),
      .err_credit      (err_credit)
`ifdef PSPIN_HER_SCHED_STATS_EN
      ,
      .stat_grants       (stat_grants),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int i, input logic [31:0] a, input logic [19:0] l,
                          input logic [31:0] t);
      src_addr[i*AW +: AW] = a;
      src_len[i*LW +: LW]  = l;
      src_tag[i*TW +: TW]  = t;
      src_valid[i]         = 1'b1;
   endtask

   // Holds feedback for n rising edges; returns at a falling edge with it low.
   task automatic fb_pulses(input logic [2:0] ctx, input int n);
      @(negedge clk);
      fb_valid  = 1'b1;
      fb_ctx_id = ctx;
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      fb_valid = 1'b0;
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (cfg_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, 64'(cfg_ack), 64'(1));
      chk({tag, "_conf"}, 64'(conf_valid), 64'(1));
      chk({tag, "_noready"}, 64'(src_ready), 64'(0));
   endtask

   task automatic do_cfg(input logic [7:0] en, input logic [63:0] lim, input string tag);
      @(negedge clk);
      cfg_req         = 1'b1;
      cfg_ctx_enabled = en;
      cfg_ctx_limit   = lim;
      #1;
      wait_ack(tag);
      @(negedge clk);
      cfg_req = 1'b0;
      #1;
      chk({tag, "_ack_off"}, 64'(cfg_ack), 64'(0));
      chk({tag, "_busy_off"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      rstn            = 1'b0;
      src_addr        = '0;
      src_len         = '0;
      src_tag         = '0;
      src_valid       = '0;
      gen_ready       = 1'b1;
      fb_valid        = 1'b0;
      fb_ctx_id       = '0;
      cfg_req         = 1'b0;
      cfg_ctx_enabled = '0;
      cfg_ctx_limit   = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gen_valid", 64'(gen_valid), 64'(0));
      chk("rst_src_ready", 64'(src_ready), 64'(0));
      chk("rst_cfg_ack", 64'(cfg_ack), 64'(0));
      chk("rst_conf_valid", 64'(conf_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'(err_credit), 64'(0));

      // T1: unlimited ctx 0, all sources valid -> 0,1,2,3,0
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < NS; i++) set_src(i, 32'h100 + 32'(i), 20'(i), 32'h0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("t1_ready", 64'(src_ready), 64'(1) << (k % 4));
         if (k > 0) begin
            chk("t1_gen_valid", 64'(gen_valid), 64'(1));
            chk("t1_gen_addr", 64'(gen_addr), 64'(32'h100 + (k - 1) % 4));
         end
      end
      @(negedge clk);
      src_valid = '0;
      #1;
      chk("t1_last_addr", 64'(gen_addr), 64'(32'h100));
      chk("t1_last_valid", 64'(gen_valid), 64'(1));
      @(negedge clk);
      #1;
      chk("t1_idle", 64'(gen_valid), 64'(0));
      fb_pulses(3'd0, 5);
      #1;
      chk("t1_no_err", 64'(err_credit), 64'(0));

      // ctx0..3 enabled; ctx0 limit 1, ctx2 limit 2, others unlimited
      do_cfg(8'h0F, 64'h0000_0000_0002_0001, "cfg1");

      // T2: ctx 2 limit 2
      @(negedge clk);
      set_src(0, 32'h200, 20'd1, 32'd2);
      #1;
      chk("t2_g1", 64'(src_ready), 64'(1));
      @(negedge clk);
      #1;
      chk("t2_g2", 64'(src_ready), 64'(1));
      chk("t2_tag", 64'(gen_tag), 64'(2));
      @(negedge clk);
      #1;
      chk("t2_stall_a", 64'(src_ready), 64'(0));
      @(negedge clk);
      #1;
      chk("t2_stall_b", 64'(src_ready), 64'(0));
      @(negedge clk);
      fb_valid  = 1'b1;
      fb_ctx_id = 3'd2;
      #1;
      chk("t2_stall_fb", 64'(src_ready), 64'(0));
      @(negedge clk);
      fb_valid = 1'b0;
      #1;
      chk("t2_g3", 64'(src_ready), 64'(1));
      @(negedge clk);
      #1;
      chk("t2_full_again", 64'(src_ready), 64'(0));
      @(negedge clk);
      src_valid = '0;
      fb_pulses(3'd2, 2);

      // T3: ctx 5 disabled -> charged to ctx 0 (limit 1)
      @(negedge clk);
      set_src(1, 32'h300, 20'd3, 32'd5);
      #1;
      chk("t3_g1", 64'(src_ready), 64'(2));
      @(negedge clk);
      #1;
      chk("t3_stall", 64'(src_ready), 64'(0));
      chk("t3_tag", 64'(gen_tag), 64'(5));
      chk("t3_addr", 64'(gen_addr), 64'(32'h300));
      @(negedge clk);
      fb_valid  = 1'b1;
      fb_ctx_id = 3'd0;
      #1;
      chk("t3_stall_fb", 64'(src_ready), 64'(0));
      @(negedge clk);
      fb_valid = 1'b0;
      #1;
      chk("t3_g2", 64'(src_ready), 64'(2));
      @(negedge clk);
      src_valid = '0;
      fb_pulses(3'd0, 1);

      // T4: back-pressure holds the slot stable
      @(negedge clk);
      gen_ready = 1'b0;
      set_src(2, 32'h400, 20'd7, 32'd1);
      #1;
      chk("t4_g1", 64'(src_ready), 64'(4));
      @(negedge clk);
      src_addr[2*AW +: AW] = 32'h401;
      #1;
      chk("t4_valid", 64'(gen_valid), 64'(1));
      chk("t4_hold_addr0", 64'(gen_addr), 64'(32'h400));
      chk("t4_hold_ready0", 64'(src_ready), 64'(0));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("t4_hold_addr", 64'(gen_addr), 64'(32'h400));
         chk("t4_hold_len", 64'(gen_len), 64'(7));
         chk("t4_hold_ready", 64'(src_ready), 64'(0));
      end
      @(negedge clk);
      gen_ready = 1'b1;
      #1;
      chk("t4_release", 64'(src_ready), 64'(4));
      @(negedge clk);
      src_valid = '0;
      #1;
      chk("t4_next_addr", 64'(gen_addr), 64'(32'h401));

      // T5: three in flight (ctx1 x2, ctx3 x1), then reconfigure
      @(negedge clk);
      set_src(3, 32'h500, 20'd5, 32'd3);
      #1;
      chk("t5_g", 64'(src_ready), 64'(8));
      @(negedge clk);
      src_valid = '0;
      #1;
      chk("t5_addr", 64'(gen_addr), 64'(32'h500));
      @(negedge clk);
      #1;
      chk("t5_idle", 64'(gen_valid), 64'(0));
      @(negedge clk);
      cfg_req         = 1'b1;
      cfg_ctx_enabled = 8'h0F;
      cfg_ctx_limit   = 64'h0000_0000_0001_0001;
      set_src(0, 32'h600, 20'd6, 32'd2);
      #1;
      chk("t5_req_nogrant", 64'(src_ready), 64'(0));
      chk("t5_req_busy", 64'(busy), 64'(0));
      @(negedge clk);
      fb_valid  = 1'b1;
      fb_ctx_id = 3'd1;
      #1;
      chk("t5_drain_busy", 64'(busy), 64'(1));
      chk("t5_drain_nogrant", 64'(src_ready), 64'(0));
      @(negedge clk);
      #1;
      chk("t5_drain_noack", 64'(cfg_ack), 64'(0));
      @(negedge clk);
      fb_ctx_id = 3'd3;
      #1;
      chk("t5_drain_noack2", 64'(cfg_ack), 64'(0));
      chk("t5_drain_noconf", 64'(conf_valid), 64'(0));
      @(negedge clk);
      fb_valid = 1'b0;
      #1;
      chk("t5_drain_noack3", 64'(cfg_ack), 64'(0));
      wait_ack("t5_ack");
      @(negedge clk);
      #1;
      chk("t5_held_req_grant", 64'(src_ready), 64'(1));
      chk("t5_held_req_busy", 64'(busy), 64'(0));
      chk("t5_ack_pulse", 64'(cfg_ack), 64'(0));
      chk("t5_conf_pulse", 64'(conf_valid), 64'(0));
      @(negedge clk);
      cfg_req = 1'b0;
      #1;
      chk("t5_new_limit", 64'(src_ready), 64'(0));
      @(negedge clk);
      src_valid = '0;
      fb_pulses(3'd2, 1);

      // T6: same-cycle grant and feedback on ctx 1
      @(negedge clk);
      set_src(1, 32'h700, 20'd9, 32'd1);
      fb_valid  = 1'b1;
      fb_ctx_id = 3'd1;
      #1;
      chk("t6_g", 64'(src_ready), 64'(2));
      @(negedge clk);
      src_valid = '0;
      fb_valid  = 1'b0;
      #1;
      chk("t6_addr", 64'(gen_addr), 64'(32'h700));
      chk("t6_no_err", 64'(err_credit), 64'(0));
      // Drain only completes if every counter, including ctx 1, is back to 0
      do_cfg(8'h0F, 64'h0000_0000_0001_0001, "t6_drain");

      // Underflow on ctx 3
      fb_pulses(3'd3, 1);
      #1;
      chk("t6_err_set", 64'(err_credit), 64'(1));
      repeat (3) @(negedge clk);
      #1;
      chk("t6_err_sticky", 64'(err_credit), 64'(1));

      // Reset mid-operation clears the slot and the sticky error
      @(negedge clk);
      set_src(0, 32'h800, 20'd8, 32'd0);
      @(negedge clk);
      src_valid = '0;
      #1;
      chk("rst2_pre_valid", 64'(gen_valid), 64'(1));
      rstn      = 1'b0;
      gen_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst2_gen_valid", 64'(gen_valid), 64'(0));
      chk("rst2_err", 64'(err_credit), 64'(0));
      rstn      = 1'b1;
      gen_ready = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
